// File: rtl/br_redirect_ctrl.sv
// br_redirect_ctrl: sequences one branch at a time from issue to resolution, turning taken outcomes into a fetch redirect plus flush window.
// Optional BR_STATS_EN adds branch/taken event counters.
module br_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BRSEL_WIDTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    input  logic [BRSEL_WIDTH-1:0] ex_brsel,
    input  logic [63:0]            ex_pc,
    output logic                   ex_ready,
    output logic                   br_exu_valid,
    input  logic                   br_taken,
    input  logic [63:0]            br_target,
    input  logic                   br_data_ok,
    output logic                   redirect_valid,
    output logic [63:0]            redirect_pc,
    input  logic                   redirect_ready,
    output logic                   flush,
    output logic                   busy
`ifdef BR_STATS_EN
    ,
    output logic [63:0]            stat_br_cnt,
    output logic [63:0]            stat_taken_cnt
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] REDIR = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES == 0 ? 0 : FLUSH_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;

    assign ex_ready       = state == IDLE;
    assign redirect_valid = state == REDIR;
    assign flush          = state == FLUSH;
    assign busy           = state != IDLE;

    // redirect_pc holds the issuing PC while waiting, then the resolved target
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            br_exu_valid <= 1'b0;
            redirect_pc  <= 64'd0;
        end else begin
            br_exu_valid <= 1'b0;
            case (state)
                IDLE: if (ex_valid && |ex_brsel) begin
                    state        <= WAIT;
                    redirect_pc  <= ex_pc;
                    br_exu_valid <= 1'b1;
                end
                WAIT: if (br_data_ok) begin
                    state <= br_taken ? REDIR : IDLE;
                    if (br_taken) redirect_pc <= br_target;
                end
                REDIR: if (redirect_ready) begin
                    state <= FLUSH_CYCLES == 0 ? IDLE : FLUSH;
                    cnt   <= FLUSH_LOAD;
                end
                default: begin
                    cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
                    if (cnt == 4'd0) state <= IDLE;
                end
            endcase
        end
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_cnt    <= 64'd0;
            stat_taken_cnt <= 64'd0;
        end else if (state == WAIT && br_data_ok) begin
            stat_br_cnt    <= stat_br_cnt + 64'd1;
            stat_taken_cnt <= stat_taken_cnt + {63'd0, br_taken};
        end
    end
`endif
endmodule

// File: tb/tb_br_redirect_ctrl.sv
// tb_br_redirect_ctrl: table-driven per-cycle checks of br_redirect_ctrl plus hand sequences
// for the FLUSH_CYCLES=0 build and (when BR_STATS_EN is defined) the statistics counters.
module tb_br_redirect_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [3:0]  ex_brsel;
    logic [63:0] ex_pc;
    logic        br_taken;
    logic [63:0] br_target;
    logic        br_data_ok;
    logic        redirect_ready;

    logic        ex_ready, br_exu_valid, redirect_valid, flush, busy;
    logic [63:0] redirect_pc;
    logic        z_ex_ready, z_br_exu_valid, z_redirect_valid, z_flush, z_busy;
    logic [63:0] z_redirect_pc;
`ifdef BR_STATS_EN
    logic [63:0] stat_br_cnt, stat_taken_cnt, z_stat_br_cnt, z_stat_taken_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    br_redirect_ctrl #(.FLUSH_CYCLES(2), .BRSEL_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_brsel(ex_brsel), .ex_pc(ex_pc),
        .ex_ready(ex_ready), .br_exu_valid(br_exu_valid), .br_taken(br_taken),
        .br_target(br_target), .br_data_ok(br_data_ok), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .flush(flush), .busy(busy)
`ifdef BR_STATS_EN
        , .stat_br_cnt(stat_br_cnt), .stat_taken_cnt(stat_taken_cnt)
`endif
    );

    br_redirect_ctrl #(.FLUSH_CYCLES(0), .BRSEL_WIDTH(4)) dut0 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_brsel(ex_brsel), .ex_pc(ex_pc),
        .ex_ready(z_ex_ready), .br_exu_valid(z_br_exu_valid), .br_taken(br_taken),
        .br_target(br_target), .br_data_ok(br_data_ok), .redirect_valid(z_redirect_valid),
        .redirect_pc(z_redirect_pc), .redirect_ready(redirect_ready), .flush(z_flush), .busy(z_busy)
`ifdef BR_STATS_EN
        , .stat_br_cnt(z_stat_br_cnt), .stat_taken_cnt(z_stat_taken_cnt)
`endif
    );

    typedef struct {
        logic        rst, ev;
        logic [3:0]  bs;
        logic [63:0] pc;
        logic        tk;
        logic [63:0] tgt;
        logic        ok, rr;
        logic        chk, e_rdy, e_exu, e_rv, e_fl, e_busy, chk_pc;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t v(input logic rst, ev, input logic [3:0] bs, input logic [63:0] pc,
                               input logic tk, input logic [63:0] tgt, input logic ok, rr,
                               input logic rdy, exu, rv, fl, bsy, cp, input logic [63:0] epc);
        vec_t r;
        r.rst = rst; r.ev = ev; r.bs = bs; r.pc = pc; r.tk = tk; r.tgt = tgt; r.ok = ok; r.rr = rr;
        r.chk = 1'b1; r.e_rdy = rdy; r.e_exu = exu; r.e_rv = rv; r.e_fl = fl; r.e_busy = bsy;
        r.chk_pc = cp; r.e_pc = epc;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ev, input logic [3:0] bs, input logic [63:0] pc,
                         input logic tk, input logic [63:0] tgt, input logic ok, rr);
        reset = rst; ex_valid = ev; ex_brsel = bs; ex_pc = pc;
        br_taken = tk; br_target = tgt; br_data_ok = ok; redirect_ready = rr;
    endtask

`ifdef BR_STATS_EN
    task automatic run_br(input logic tk);
        int n;
        @(negedge clk); drive(0, 1, 4'd1, 64'h1000, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 4'd0, 0, tk, 64'h2000, 1, 1);
        @(negedge clk); drive(0, 0, 4'd0, 0, 0, 0, 0, 1);
        n = 0;
        while (!ex_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stats_idle_timeout", {63'd0, ex_ready}, 64'd1);
    endtask
`endif

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        //              rst ev bs  pc               tk tgt              ok rr  rdy exu rv fl bsy cp epc
        vecs[0]  = v(1, 0, 0, 0,               0, 0,               0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[0].chk = 1'b0;
        vecs[1]  = v(0, 0, 0, 0,               0, 0,               0, 0,  1, 0, 0, 0, 0, 1, 0);
        vecs[2]  = v(0, 1, 1, 64'h8000_0000,   0, 0,               0, 1,  1, 0, 0, 0, 0, 0, 0);
        vecs[3]  = v(0, 0, 0, 0,               1, 64'h8000_0040,   1, 1,  0, 1, 0, 0, 1, 0, 0);
        vecs[4]  = v(0, 0, 0, 0,               0, 0,               0, 1,  0, 0, 1, 0, 1, 1, 64'h8000_0040);
        vecs[5]  = v(0, 0, 0, 0,               0, 0,               0, 1,  0, 0, 0, 1, 1, 0, 0);
        vecs[6]  = v(0, 0, 0, 0,               0, 0,               0, 1,  0, 0, 0, 1, 1, 0, 0);
        vecs[7]  = v(0, 1, 2, 64'h100,         0, 0,               0, 1,  1, 0, 0, 0, 0, 0, 0);
        vecs[8]  = v(0, 0, 0, 0,               0, 64'hdead,        1, 1,  0, 1, 0, 0, 1, 0, 0);
        vecs[9]  = v(0, 1, 0, 64'h180,         0, 0,               0, 1,  1, 0, 0, 0, 0, 0, 0);
        vecs[10] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[11] = v(0, 1, 3, 64'h200,         1, 64'h3000,        1, 0,  0, 1, 0, 0, 1, 0, 0);
        vecs[12] = v(0, 1, 3, 64'h200,         1, 64'h4444,        1, 0,  0, 0, 1, 0, 1, 1, 64'h3000);
        vecs[13] = v(0, 1, 3, 64'h200,         0, 64'h5555,        0, 0,  0, 0, 1, 0, 1, 1, 64'h3000);
        vecs[14] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  0, 0, 1, 0, 1, 1, 64'h3000);
        vecs[15] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  0, 0, 1, 0, 1, 1, 64'h3000);
        vecs[16] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  0, 0, 1, 0, 1, 1, 64'h3000);
        vecs[17] = v(0, 1, 3, 64'h200,         0, 0,               0, 1,  0, 0, 1, 0, 1, 1, 64'h3000);
        vecs[18] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  0, 0, 0, 1, 1, 0, 0);
        vecs[19] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  0, 0, 0, 1, 1, 0, 0);
        vecs[20] = v(0, 1, 3, 64'h200,         0, 0,               0, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[21] = v(0, 0, 0, 0,               1, 64'h5000,        1, 0,  0, 1, 0, 0, 1, 0, 0);
        vecs[22] = v(1, 0, 0, 0,               0, 0,               0, 0,  0, 0, 1, 0, 1, 1, 64'h5000);
        vecs[23] = v(0, 0, 0, 0,               0, 0,               0, 1,  1, 0, 0, 0, 0, 1, 0);
        vecs[24] = v(0, 1, 1, 64'h700,         0, 0,               0, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[25] = v(0, 0, 0, 0,               0, 0,               0, 0,  0, 1, 0, 0, 1, 0, 0);
        vecs[26] = v(0, 0, 0, 0,               0, 0,               0, 0,  0, 0, 0, 0, 1, 0, 0);
        vecs[27] = v(0, 0, 0, 0,               0, 64'h9999,        1, 0,  0, 0, 0, 0, 1, 0, 0);
        vecs[28] = v(0, 0, 0, 0,               0, 0,               0, 0,  1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ev, vecs[i].bs, vecs[i].pc, vecs[i].tk, vecs[i].tgt,
                  vecs[i].ok, vecs[i].rr);
            if (vecs[i].chk) begin
                check($sformatf("v%0d ex_ready", i), {63'd0, ex_ready}, {63'd0, vecs[i].e_rdy});
                check($sformatf("v%0d br_exu_valid", i), {63'd0, br_exu_valid}, {63'd0, vecs[i].e_exu});
                check($sformatf("v%0d redirect_valid", i), {63'd0, redirect_valid}, {63'd0, vecs[i].e_rv});
                check($sformatf("v%0d flush", i), {63'd0, flush}, {63'd0, vecs[i].e_fl});
                check($sformatf("v%0d busy", i), {63'd0, busy}, {63'd0, vecs[i].e_busy});
                if (vecs[i].chk_pc) check($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].e_pc);
            end
        end

        // FLUSH_CYCLES=0: taken branch returns to IDLE right after the handshake, never flushing
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 1, 4'd1, 64'h10, 0, 0, 0, 1);
        @(negedge clk); drive(0, 0, 0, 0, 1, 64'h20, 1, 1);
        check("f0 T1 busy", {63'd0, z_busy}, 64'd1);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("f0 T2 redirect_valid", {63'd0, z_redirect_valid}, 64'd1);
        check("f0 T2 redirect_pc", z_redirect_pc, 64'h20);
        check("f0 T2 flush", {63'd0, z_flush}, 64'd0);
        @(negedge clk);
        check("f0 T3 redirect_valid", {63'd0, z_redirect_valid}, 64'd0);
        check("f0 T3 flush", {63'd0, z_flush}, 64'd0);
        check("f0 T3 busy", {63'd0, z_busy}, 64'd0);
        check("f0 T3 ex_ready", {63'd0, z_ex_ready}, 64'd1);
        @(negedge clk);
        check("f0 T4 flush", {63'd0, z_flush}, 64'd0);

`ifdef BR_STATS_EN
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("stat_br_cnt reset", stat_br_cnt, 64'd0);
        check("stat_taken_cnt reset", stat_taken_cnt, 64'd0);
        run_br(1); run_br(0); run_br(1); run_br(0); run_br(1);
        check("stat_br_cnt", stat_br_cnt, 64'd5);
        check("stat_taken_cnt", stat_taken_cnt, 64'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/br_redirect_ctrl.md
# br_redirect_ctrl

Sequences one branch/jump operation at a time through the branch unit, from issue to resolved outcome. Taken outcomes become a single fetch redirect with a valid/ready handshake and a bounded flush window; not-taken outcomes retire with no side effects. Sits between the execute issue logic and the `br` datapath on one side and the IFU redirect port and pipeline flush net on the other. Exactly one branch is in flight at a time.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high after a redirect is accepted. Legal range 0..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  branch op presented by issue logic.
- `ex_brsel`  in  `BRSEL_WIDTH`  branch selector of the presented op; 0 means not a branch.
- `ex_pc`  in  64  PC of the presented op.
- `ex_ready`  out  1  controller can accept an op this cycle.
- `br_exu_valid`  out  1  drives the branch unit's `exu_valid`; one-cycle pulse on accept.
- `br_taken`  in  1  branch unit `redirect_valid`.
- `br_target`  in  64  branch unit `br_out`.
- `br_data_ok`  in  1  branch unit result-valid strobe.
- `redirect_valid`  out  1  redirect request to the IFU.
- `redirect_pc`  out  64  redirect target.
- `redirect_ready`  in  1  IFU accepts the redirect.
- `flush`  out  1  kills younger in-flight instructions.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, REDIR, FLUSH. All four are reached only from the transitions listed below.
- IDLE
  - `ex_ready` is 1.
  - Accept occurs when `ex_valid` is high and `ex_brsel` is nonzero. On accept: latch `ex_pc`, pulse `br_exu_valid`, go to WAIT.
  - `ex_valid` with `ex_brsel` equal to 0 is ignored.
- WAIT
  - `ex_ready` is 0.
  - `br_taken` and `br_target` are sampled only in a cycle where `br_data_ok` is 1.
  - Taken result: latch `br_target` into `redirect_pc`, go to REDIR.
  - Not-taken result: go to IDLE.
  - `br_data_ok` low: stay in WAIT, no timeout.
- REDIR
  - `redirect_valid` is 1; `redirect_pc` is held stable until the handshake.
  - Handshake occurs when `redirect_valid` and `redirect_ready` are both high.
  - On handshake: go to FLUSH, loading the counter with `FLUSH_CYCLES`-1. If `FLUSH_CYCLES` is 0, go directly to IDLE.
- FLUSH
  - `flush` is 1.
  - Counter decrements each cycle; go to IDLE in the cycle the counter reads 0.
- While not in IDLE, `ex_valid` is ignored. Upstream holds the op until `ex_ready` is high.
- `br_data_ok` outside WAIT is ignored; no state change.
- Reset values: state IDLE, `ex_ready`=1, `br_exu_valid`=0, `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `busy`=0, counter 0.
- Reset asserted mid-operation: return to IDLE on that edge. The pending redirect is dropped, no flush is issued, and the latched PC is not retained.

## Timing
- Accept at T0. Branch unit registers its result, so `br_data_ok` arrives at T1 and WAIT is entered at T1.
- Not-taken branch: IDLE at T2; `ex_ready` is 1 at T2. Throughput is one branch per 2 cycles.
- Taken branch: REDIR and `redirect_valid` at T2.
  - With `redirect_ready`=1 at T2: `flush` is high T3..T2+`FLUSH_CYCLES`; IDLE at T3+`FLUSH_CYCLES`.
- Each cycle of IFU backpressure (`redirect_ready` low) extends REDIR by one cycle.
- All outputs are functions of registered state only; no combinational input-to-output path.

## Configuration
- `BR_STATS_EN` defined:
  - Adds two 64-bit output ports, `stat_br_cnt` and `stat_taken_cnt`, both 0 at reset.
  - `stat_br_cnt` increments on each WAIT resolution.
  - `stat_taken_cnt` increments on each taken resolution.
  - Both counters wrap from all-ones to 0.
- `BR_STATS_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then bne with rs1 != rs2, pc=0x8000_0000, target 0x8000_0040, `redirect_ready`=1 -> `redirect_valid` at T2 with `redirect_pc`=0x8000_0040; `flush` high exactly 2 cycles; `ex_ready` high at T5.
- beq not taken, pc=0x100 -> `redirect_valid` and `flush` never assert; `ex_ready` high at T2.
- jalr with `redirect_ready` low for 5 cycles -> `redirect_valid` high for 6 cycles, `redirect_pc` constant throughout, `flush` starts the cycle after the handshake.
- `ex_valid`=1 held continuously with `ex_brsel`=3 during REDIR -> no second `br_exu_valid` pulse until IDLE; `ex_brsel`=0 in IDLE -> no accept.
- `reset` pulsed in REDIR -> next cycle `redirect_valid`=0, `busy`=0, `flush`=0; `FLUSH_CYCLES`=0 build -> taken branch returns to IDLE the cycle after the handshake with no `flush`.
- `BR_STATS_EN` defined, 3 taken and 2 not-taken branches -> `stat_br_cnt`=5, `stat_taken_cnt`=3.
